// File: rtl/multi_cycle_control.sv
// Multi-cycle datapath controller: Moore FSM sequencing fetch, decode and
// per-class execution, with a bounded wait on the shared memory and sticky
// fault reporting for memory timeouts and undefined opcodes.
module multi_cycle_control #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       SignExtend,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [3:0] State,
    output logic       Fault,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IMMEX  = 4'd10,
        IMMWB  = 4'd11,
        ERROR  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [5:0] opc_q, opc_d;
    logic       fault_q, fault_d;
    logic       illegal_q, illegal_d;
    logic       timeout;
    logic       in_wait_state;

    assign timeout       = (wait_q == WAIT_LAST) && !MemReady;
    assign in_wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

    // State, wait counter, latched opcode and sticky flags
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            opc_q     <= '0;
            fault_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            opc_q     <= opc_d;
            fault_q   <= fault_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state selection, opcode capture and wait-counter update
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH:  if (MemReady) state_d = DECODE; else if (timeout) state_d = ERROR;
            DECODE: begin
                opc_d = Opcode;
                case (Opcode)
                    OP_LW, OP_SW:     state_d = MEMADR;
                    OP_RTYPE:         state_d = EXEC;
                    OP_BEQ:           state_d = BRANCH;
                    OP_J:             state_d = JUMP;
                    OP_ADDI, OP_ORI:  state_d = IMMEX;
                    default: begin
                        state_d   = ERROR;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (opc_q == OP_LW)      state_d = MEMRD;
                else if (opc_q == OP_SW) state_d = MEMWR;
                else                     state_d = ERROR;
            end
            MEMRD:  if (MemReady) state_d = MEMWB; else if (timeout) state_d = ERROR;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (MemReady) state_d = FETCH; else if (timeout) state_d = ERROR;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
            IMMEX:  state_d = IMMWB;
            IMMWB:  state_d = FETCH;
            ERROR:  state_d = ERROR;
            default: state_d = ERROR;
        endcase

        fault_d = fault_q || (state_d == ERROR);

        // Counter restarts whenever the state changes, so every entry to a
        // waiting state begins at zero.
        if (state_d != state_q)
            wait_d = '0;
        else if (in_wait_state && !MemReady)
            wait_d = wait_q + 8'd1;
        else
            wait_d = wait_q;
    end

    // Moore control decode; FETCH additionally qualifies IR/PC writes with MemReady
    always_comb begin
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        ALUSrcA     = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        SignExtend  = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 4'b0000;
        if (!Reset) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                DECODE: begin
                    ALUSrcB    = 2'b11;
                    SignExtend = 1'b1;
                end
                MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    SignExtend = 1'b1;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 4'b0010;
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 4'b0001;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                IMMEX, IMMWB: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    if (opc_q == OP_ORI) begin
                        ALUOp = 4'b0011;
                    end else begin
                        SignExtend = 1'b1;
                    end
                    RegWrite = (state_q == IMMWB);
                end
                default: ;
            endcase
        end
    end

    assign State     = state_q;
    assign Fault     = fault_q;
    assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed table, hand-written
// corner sequences and a randomized instruction stream against a model.
module tb_multi_cycle_control;

    typedef struct packed {
        logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
        logic       ALUSrcA, RegDst, MemToReg, RegWrite, SignExtend;
        logic [1:0] ALUSrcB;
        logic [1:0] PCSource;
        logic [3:0] ALUOp;
    } ctrl_t;

    typedef struct {
        logic       rst;
        logic [5:0] opc;
        logic       mr;
        logic [3:0] st;
        logic       memread, regwrite, regdst, pcwc, pcwrite;
        logic [3:0] aluop;
        logic [1:0] pcsrc;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    logic MemReady = 1'b0;
    logic [5:0] Opcode = '0;

    int total = 0;
    int bad = 0;

    logic a_IorD, a_MemRead, a_MemWrite, a_IRWrite, a_PCWrite, a_PCWriteCond;
    logic a_ALUSrcA, a_RegDst, a_MemToReg, a_RegWrite, a_SignExtend, a_Fault, a_IllegalOp;
    logic [1:0] a_ALUSrcB, a_PCSource;
    logic [3:0] a_ALUOp, a_State;
    logic b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_PCWrite, b_PCWriteCond;
    logic b_ALUSrcA, b_RegDst, b_MemToReg, b_RegWrite, b_SignExtend, b_Fault, b_IllegalOp;
    logic [1:0] b_ALUSrcB, b_PCSource;
    logic [3:0] b_ALUOp, b_State;
    ctrl_t act_a, act_b;

    assign act_a = {a_IorD, a_MemRead, a_MemWrite, a_IRWrite, a_PCWrite, a_PCWriteCond,
                    a_ALUSrcA, a_RegDst, a_MemToReg, a_RegWrite, a_SignExtend,
                    a_ALUSrcB, a_PCSource, a_ALUOp};
    assign act_b = {b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_PCWrite, b_PCWriteCond,
                    b_ALUSrcA, b_RegDst, b_MemToReg, b_RegWrite, b_SignExtend,
                    b_ALUSrcB, b_PCSource, b_ALUOp};

    multi_cycle_control dut_a (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .IorD(a_IorD), .MemRead(a_MemRead), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite),
        .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .ALUSrcA(a_ALUSrcA),
        .RegDst(a_RegDst), .MemToReg(a_MemToReg), .RegWrite(a_RegWrite),
        .SignExtend(a_SignExtend), .ALUSrcB(a_ALUSrcB), .PCSource(a_PCSource),
        .ALUOp(a_ALUOp), .State(a_State), .Fault(a_Fault), .IllegalOp(a_IllegalOp)
    );

    multi_cycle_control #(.MAX_WAIT(4)) dut_b (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .IorD(b_IorD), .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
        .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .ALUSrcA(b_ALUSrcA),
        .RegDst(b_RegDst), .MemToReg(b_MemToReg), .RegWrite(b_RegWrite),
        .SignExtend(b_SignExtend), .ALUSrcB(b_ALUSrcB), .PCSource(b_PCSource),
        .ALUOp(b_ALUOp), .State(b_State), .Fault(b_Fault), .IllegalOp(b_IllegalOp)
    );

    always #5 CLK = ~CLK;

    // Expected controls for a state number, written from the per-state rules
    function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] lop, input logic mr);
        ctrl_t c = '0;
        case (st)
            0:  begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.IRWrite = mr; c.PCWrite = mr; end
            1:  begin c.ALUSrcB = 2'b11; c.SignExtend = 1; end
            2:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.SignExtend = 1; end
            3:  begin c.MemRead = 1; c.IorD = 1; end
            4:  begin c.MemToReg = 1; c.RegWrite = 1; end
            5:  begin c.MemWrite = 1; c.IorD = 1; end
            6:  begin c.ALUSrcA = 1; c.ALUOp = 4'b0010; end
            7:  begin c.RegDst = 1; c.RegWrite = 1; end
            8:  begin c.ALUSrcA = 1; c.ALUOp = 4'b0001; c.PCWriteCond = 1; c.PCSource = 2'b01; end
            9:  begin c.PCWrite = 1; c.PCSource = 2'b10; end
            10, 11: begin
                c.ALUSrcA = 1; c.ALUSrcB = 2'b10;
                if (lop == ORI) c.ALUOp = 4'b0011; else c.SignExtend = 1;
                c.RegWrite = (st == 11);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic chk(input string nm, input int which, input int st, input logic f,
                       input logic il, input logic [5:0] lop);
        ctrl_t ac, ec;
        logic [3:0] ast;
        logic af, ail;
        ec = Reset ? ctrl_t'('0) : exp_ctrl(st, lop, MemReady);
        if (which == 0) begin ac = act_a; ast = a_State; af = a_Fault; ail = a_IllegalOp; end
        else            begin ac = act_b; ast = b_State; af = b_Fault; ail = b_IllegalOp; end
        total++;
        if (ast !== 4'(st) || ac !== ec || af !== f || ail !== il) begin
            bad++;
            $display("FAIL %s dut%0d: got state=%0d ctrl=%h fault=%b ill=%b, want state=%0d ctrl=%h fault=%b ill=%b",
                     nm, which, ast, ac, af, ail, st, ec, f, il);
        end
    endtask

    // Check at the falling edge with current inputs, then advance one cycle
    task automatic step(input string nm, input logic [5:0] lop, input int sta, input logic fa,
                        input logic ila, input int stb = -1, input logic fb = 1'b0,
                        input logic ilb = 1'b0);
        @(negedge CLK);
        chk(nm, 0, sta, fa, ila, lop);
        if (stb >= 0) chk(nm, 1, stb, fb, ilb, lop);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        MemReady = 1'b0;
        Opcode = '0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    // One non-waiting state with unrelated inputs randomized
    task automatic rnd_step(input string nm, input logic [5:0] lop, input int st);
        MemReady = 1'($urandom);
        Opcode = 6'($urandom);
        step(nm, lop, st, 1'b0, 1'b0, st, 1'b0, 1'b0);
    endtask

    // A memory-waiting state held for n cycles, then completed
    task automatic wait_step(input string nm, input logic [5:0] lop, input int st, input int n);
        for (int k = 0; k <= n; k++) begin
            MemReady = (k == n);
            Opcode = 6'($urandom);
            step(nm, lop, st, 1'b0, 1'b0, st, 1'b0, 1'b0);
        end
    endtask

    vec_t tbl[10];
    logic [5:0] ops[7];

    initial begin
        tbl[0] = '{1'b1, RT,  1'b1, 4'd0, 0, 0, 0, 0, 0, 4'b0000, 2'b00};
        tbl[1] = '{1'b0, RT,  1'b1, 4'd0, 1, 0, 0, 0, 1, 4'b0000, 2'b00};
        tbl[2] = '{1'b0, RT,  1'b1, 4'd1, 0, 0, 0, 0, 0, 4'b0000, 2'b00};
        tbl[3] = '{1'b0, RT,  1'b1, 4'd6, 0, 0, 0, 0, 0, 4'b0010, 2'b00};
        tbl[4] = '{1'b0, RT,  1'b1, 4'd7, 0, 1, 1, 0, 0, 4'b0000, 2'b00};
        tbl[5] = '{1'b0, BEQ, 1'b1, 4'd0, 1, 0, 0, 0, 1, 4'b0000, 2'b00};
        tbl[6] = '{1'b0, BEQ, 1'b1, 4'd1, 0, 0, 0, 0, 0, 4'b0000, 2'b00};
        tbl[7] = '{1'b0, BEQ, 1'b1, 4'd8, 0, 0, 0, 1, 0, 4'b0001, 2'b01};
        tbl[8] = '{1'b0, BEQ, 1'b1, 4'd0, 1, 0, 0, 0, 1, 4'b0000, 2'b00};
        tbl[9] = '{1'b0, LW,  1'b0, 4'd1, 0, 0, 0, 0, 0, 4'b0000, 2'b00};
        ops = '{LW, SW, RT, BEQ, JMP, ADDI, ORI};

        do_reset();

        // Directed table: R-type then beq with memory always ready
        for (int i = 0; i < 10; i++) begin
            Reset = tbl[i].rst;
            Opcode = tbl[i].opc;
            MemReady = tbl[i].mr;
            @(negedge CLK);
            total++;
            if (a_State !== tbl[i].st || a_MemRead !== tbl[i].memread ||
                a_RegWrite !== tbl[i].regwrite || a_RegDst !== tbl[i].regdst ||
                a_PCWriteCond !== tbl[i].pcwc || a_PCWrite !== tbl[i].pcwrite ||
                a_ALUOp !== tbl[i].aluop || a_PCSource !== tbl[i].pcsrc) begin
                bad++;
                $display("FAIL vec[%0d]: got st=%0d mr=%b rw=%b rd=%b pwc=%b pw=%b op=%b ps=%b, want st=%0d mr=%b rw=%b rd=%b pwc=%b pw=%b op=%b ps=%b",
                         i, a_State, a_MemRead, a_RegWrite, a_RegDst, a_PCWriteCond, a_PCWrite,
                         a_ALUOp, a_PCSource, tbl[i].st, tbl[i].memread, tbl[i].regwrite,
                         tbl[i].regdst, tbl[i].pcwc, tbl[i].pcwrite, tbl[i].aluop, tbl[i].pcsrc);
            end
            @(posedge CLK);
            #1;
        end

        // lw with three wait cycles in MEMRD
        do_reset();
        Opcode = LW; MemReady = 1'b1;
        step("lw_fetch", LW, 0, 0, 0);
        step("lw_dec", LW, 1, 0, 0);
        step("lw_adr", LW, 2, 0, 0);
        MemReady = 1'b0;
        repeat (3) step("lw_rd_wait", LW, 3, 0, 0, 3, 0, 0);
        MemReady = 1'b1;
        step("lw_rd", LW, 3, 0, 0);
        step("lw_wb", LW, 4, 0, 0);
        step("lw_fetch2", LW, 0, 0, 0);

        // Undefined opcode: sticky ERROR until reset
        do_reset();
        Opcode = 6'b111111; MemReady = 1'b1;
        step("ill_fetch", Opcode, 0, 0, 0);
        step("ill_dec", Opcode, 1, 0, 0);
        repeat (20) step("ill_err", Opcode, 12, 1, 1);
        Reset = 1'b1;
        step("ill_rst_edge", Opcode, 12, 1, 1);
        step("ill_rst_held", Opcode, 0, 0, 0);
        Reset = 1'b0;
        step("ill_after", Opcode, 0, 0, 0);

        // Memory timeout in FETCH: dut_b (MAX_WAIT=4) and dut_a (default 15)
        do_reset();
        MemReady = 1'b0;
        for (int k = 0; k < 4; k++) step("to_fetch", 6'd0, 0, 0, 0, 0, 0, 0);
        for (int k = 4; k < 15; k++) step("to_wait", 6'd0, 0, 0, 0, 12, 1, 0);
        step("to_err", 6'd0, 12, 1, 0, 12, 1, 0);

        // Ready on the last allowed cycle wins over the timeout
        do_reset();
        Opcode = RT; MemReady = 1'b0;
        for (int k = 0; k < 3; k++) step("rescue_fetch", 6'd0, 0, 0, 0, 0, 0, 0);
        MemReady = 1'b1;
        step("rescue_ready", 6'd0, 0, 0, 0, 0, 0, 0);
        step("rescue_dec", 6'd0, 1, 0, 0, 1, 0, 0);

        // Reset while stalled in MEMWR
        do_reset();
        Opcode = SW; MemReady = 1'b1;
        step("sw_fetch", SW, 0, 0, 0);
        step("sw_dec", SW, 1, 0, 0);
        step("sw_adr", SW, 2, 0, 0);
        MemReady = 1'b0;
        repeat (2) step("sw_wait", SW, 5, 0, 0);
        Reset = 1'b1;
        step("sw_rst_edge", SW, 5, 0, 0);
        step("sw_rst_held", SW, 0, 0, 0);
        Reset = 1'b0;
        step("sw_after", SW, 0, 0, 0);

        // Random instruction stream with random memory latencies
        do_reset();
        begin
            logic [5:0] lop = '0;
            for (int n = 0; n < 60; n++) begin
                logic [5:0] opc = ops[$urandom_range(0, 6)];
                int wf = $urandom_range(0, 3);
                int wm = $urandom_range(0, 3);
                wait_step("rnd_fetch", lop, 0, wf);
                Opcode = opc;
                MemReady = 1'($urandom);
                step("rnd_dec", lop, 1, 0, 0, 1, 0, 0);
                lop = opc;
                case (opc)
                    LW:  begin rnd_step("rnd_lw", lop, 2); wait_step("rnd_lw", lop, 3, wm); rnd_step("rnd_lw", lop, 4); end
                    SW:  begin rnd_step("rnd_sw", lop, 2); wait_step("rnd_sw", lop, 5, wm); end
                    RT:  begin rnd_step("rnd_rt", lop, 6); rnd_step("rnd_rt", lop, 7); end
                    BEQ: rnd_step("rnd_beq", lop, 8);
                    JMP: rnd_step("rnd_j", lop, 9);
                    default: begin rnd_step("rnd_imm", lop, 10); rnd_step("rnd_imm", lop, 11); end
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter MAX_WAIT, default 15: cycles a memory state may see MemReady low before faulting; legal range 1-255.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  6  instruction bits [31:26] from the datapath instruction register.
REQ-005 MemReady  input  1  shared memory completes the current read or write this cycle.
REQ-006 Control outputs, all width 1: IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA, RegDst, MemToReg, RegWrite, SignExtend.
REQ-007 ALUSrcB  output  2  ALU B select: 00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2.
REQ-008 PCSource  output  2  next-PC select: 00 ALU result, 01 ALUOut register, 10 jump address.
REQ-009 ALUOp  output  4  0000 add, 0001 sub, 0010 decode funct, 0011 or.
REQ-010 State  output  4  current state encoding per REQ-013.
REQ-011 Fault  output  1  sticky error flag.
REQ-012 IllegalOp  output  1  sticky flag, set when the Fault cause is an undefined opcode.

Function
REQ-013 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11, ERROR=12; codes 13-15 go to ERROR next cycle.
REQ-014 Outputs are Moore, decoded from State plus the latched opcode; the only exception is MemReady qualification in FETCH.
REQ-015 Every output not listed for a state is 0.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add; IRWrite=PCWrite=MemReady; moves to DECODE when MemReady=1, otherwise holds.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add, SignExtend=1; Opcode latched into an internal register this cycle.
REQ-018 DECODE next state by Opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 or 001101 -> IMMEX; any other -> ERROR with IllegalOp set.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=add, SignExtend=1; goes to MEMRD if the latched opcode is lw, MEMWR if sw.
REQ-020 MEMRD: MemRead=1, IorD=1; goes to MEMWB on MemReady, otherwise holds.
REQ-021 MEMWB: RegDst=0, MemToReg=1, RegWrite=1; goes to FETCH.
REQ-022 MEMWR: MemWrite=1, IorD=1; goes to FETCH on MemReady, otherwise holds.
REQ-023 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=funct; goes to ALUWB.
REQ-024 ALUWB: RegDst=1, MemToReg=0, RegWrite=1; goes to FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01; goes to FETCH.
REQ-026 JUMP: PCWrite=1, PCSource=10; goes to FETCH.
REQ-027 IMMEX: ALUSrcA=1, ALUSrcB=10.
REQ-028 IMMEX for addi: ALUOp=add, SignExtend=1. For ori: ALUOp=or, SignExtend=0.
REQ-029 IMMEX goes to IMMWB.
REQ-030 IMMWB: same ALU controls as IMMEX, plus RegDst=0, MemToReg=0, RegWrite=1; goes to FETCH.
REQ-031 Cycle counts with MemReady high on first cycle: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3.
REQ-032 Wait counter, 8-bit: cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle in those states while MemReady=0.
REQ-033 In FETCH, MEMRD or MEMWR, when MemReady=0 and the counter equals MAX_WAIT-1, the next state is ERROR and Fault is set.
REQ-034 MemReady=1 in that same cycle takes priority over the timeout.
REQ-035 ERROR: all controls 0, Fault=1; held until Reset.
REQ-036 MemRead and MemWrite are never both 1; RegWrite and either PCWrite or PCWriteCond are never both 1 in one cycle.

Reset
REQ-037 Reset=1 at a clock edge sets State=FETCH and clears the wait counter, latched opcode, Fault and IllegalOp.
REQ-038 While Reset=1, all control outputs are forced to 0.
REQ-039 The first cycle after Reset falls presents FETCH outputs.
REQ-040 Reset in any state, including mid-wait and ERROR, takes effect at the next edge.

Verification
REQ-041 Opcode=000000, MemReady=1 constant -> State sequence 0,1,6,7,0; RegWrite=1 only in state 7, with RegDst=1.
REQ-042 Opcode=100011, MemReady low for 3 cycles in MEMRD -> State 0,1,2,3,3,3,3,4,0; MemRead=1 and IorD=1 held through all MEMRD cycles.
REQ-043 Opcode=000100 -> State 0,1,8,0; in state 8 PCWriteCond=1, ALUOp=0001, PCSource=01, PCWrite=0.
REQ-044 Opcode=111111 -> State 0,1,12; Fault=1 and IllegalOp=1 held for 20 cycles; Reset pulse -> State=0, both flags 0.
REQ-045 MAX_WAIT=4, MemReady=0 forever from FETCH -> 4 FETCH cycles then State=12 with Fault=1, IllegalOp=0. Repeat with MemReady=1 on the 4th cycle -> State=1, no fault.
REQ-046 Reset asserted in MEMWR with MemReady=0 -> next cycle all outputs 0; after release State=0 with MemWrite=0.
